// File: rtl/imem_port_arbiter.sv
// Arbiter and sequencer between the CPU fetch port (A), the loader/debug port (B)
// and a single-port, byte-writable instruction RAM with one-cycle read latency.
module imem_port_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [31:0]       a_rdata,

    input  logic              b_req,
    input  logic [3:0]        b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       b_wdata,
    input  logic              b_lock,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [31:0]       b_rdata,

    output logic [3:0]        ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [31:0]       ram_dina,
    input  logic [31:0]       ram_douta
);

    localparam logic ST_ARB  = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic              state_q;
    logic              state_d;
    logic [3:0]        wait_q;
    logic [3:0]        wait_d;
    logic [ADDR_W-1:0] addr_q;
    logic              tag_valid_q;
    logic              tag_owner_q;   // 1: the pending read belongs to B
    logic              b_read;

    // Grants are combinational from this cycle's requests so the RAM sees the
    // winner's address on the same edge; reset suppresses every grant.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an uncovered path infers a latch.
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst) begin
            if (state_q == ST_LOCK) begin
                b_gnt = b_req;
            end else if (a_req && b_req) begin
                if (wait_q == WAIT_LIMIT) begin
                    b_gnt = 1'b1;
                end else begin
                    a_gnt = 1'b1;
                end
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB: begin
                if (b_gnt && b_lock) begin
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (!b_req || (b_gnt && !b_lock)) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // Saturating count of consecutive cycles B has been kept waiting.
    always_comb begin
        wait_d = wait_q;
        if (b_gnt || !b_req) begin
            wait_d = 4'd0;
        end else if (wait_q < WAIT_LIMIT) begin
            wait_d = wait_q + 4'd1;
        end
    end

    // With no winner the address is held so the RAM never sees a new location
    // alongside a stale write enable.
    always_comb begin
        if (a_gnt) begin
            ram_addra = a_addr;
        end else if (b_gnt) begin
            ram_addra = b_addr;
        end else begin
            ram_addra = addr_q;
        end
    end

    assign ram_wea  = b_gnt ? b_we : 4'b0000;
    assign ram_dina = b_wdata;
    assign b_read   = b_gnt && (b_we == 4'b0000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ARB;
            wait_q      <= 4'd0;
            addr_q      <= '0;
            tag_valid_q <= 1'b0;
            tag_owner_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q     <= state_d;
            wait_q      <= wait_d;
            addr_q      <= ram_addra;
            tag_valid_q <= a_gnt || b_read;
            tag_owner_q <= b_gnt;
        end
    end

    // The RAM registers its output, so the tag from the previous edge lines up
    // with the data currently on ram_douta.
    assign a_rvalid = tag_valid_q && !tag_owner_q;
    assign b_rvalid = tag_valid_q && tag_owner_q;
    assign a_rdata  = ram_douta;
    assign b_rdata  = ram_douta;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural byte-writable RAM;
// read expectations go into a scoreboard drained by an rvalid monitor.
module tb_imem_port_arbiter;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              rst;
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_gnt;
    logic              a_rvalid;
    logic [31:0]       a_rdata;
    logic              b_req;
    logic [3:0]        b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [31:0]       b_wdata;
    logic              b_lock;
    logic              b_gnt;
    logic              b_rvalid;
    logic [31:0]       b_rdata;
    logic [3:0]        ram_wea;
    logic [ADDR_W-1:0] ram_addra;
    logic [31:0]       ram_dina;
    logic [31:0]       ram_douta;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    imem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_addr    (a_addr),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_lock    (b_lock),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_douta (ram_douta)
    );

    // Behavioural RAM: byte write enables, registered read-first output.
    logic [31:0] mem [0:(1<<ADDR_W)-1];

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        mem[5] = 32'h00B12023;
        mem[6] = 32'hDEADBEEF;
        mem[8] = 32'h11223344;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_wea[i]) mem[ram_addra][i*8 +: 8] <= ram_dina[i*8 +: 8];
        end
        ram_douta <= mem[ram_addra];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion before 100000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (a_rvalid || b_rvalid) begin
            check("rvalid_onehot", {31'b0, a_rvalid && b_rvalid}, 32'h0);
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got a_rvalid=%0b b_rvalid=%0b, want none", a_rvalid, b_rvalid);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rvalid_owner", {31'b0, b_rvalid}, {31'b0, e.owner});
                check("rdata", e.owner ? b_rdata : a_rdata, e.data);
            end
        end
    end

    // One cycle of stimulus: drive, check grants/RAM drive mid-cycle, queue reads.
    task automatic step(input logic ar, input logic [ADDR_W-1:0] aad,
                        input logic br, input logic [3:0] bw, input logic [ADDR_W-1:0] bad,
                        input logic [31:0] bwd, input logic bl,
                        input logic eag, input logic ebg, input logic [31:0] erd,
                        input string nm);
        exp_t e;
        a_req   = ar;
        a_addr  = aad;
        b_req   = br;
        b_we    = bw;
        b_addr  = bad;
        b_wdata = bwd;
        b_lock  = bl;
        @(negedge clk);
        check({nm, "_a_gnt"}, {31'b0, a_gnt}, {31'b0, eag});
        check({nm, "_b_gnt"}, {31'b0, b_gnt}, {31'b0, ebg});
        check({nm, "_wea"}, {28'b0, ram_wea}, {28'b0, ebg ? bw : 4'b0000});
        if (eag) check({nm, "_addra"}, {20'b0, ram_addra}, {20'b0, aad});
        if (ebg) check({nm, "_addra"}, {20'b0, ram_addra}, {20'b0, bad});
        if (eag) begin
            e.owner = 1'b0;
            e.data  = erd;
            sb_q.push_back(e);
        end
        if (ebg && bw == 4'b0000) begin
            e.owner = 1'b1;
            e.data  = erd;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        a_req   = 1'b1;
        a_addr  = 12'd5;
        b_req   = 1'b1;
        b_we    = 4'b0000;
        b_addr  = 12'd8;
        b_wdata = 32'h0;
        b_lock  = 1'b0;

        // Reset held with both requests active.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_gnt", {31'b0, a_gnt}, 32'h0);
        check("rst_b_gnt", {31'b0, b_gnt}, 32'h0);
        check("rst_a_rvalid", {31'b0, a_rvalid}, 32'h0);
        check("rst_b_rvalid", {31'b0, b_rvalid}, 32'h0);
        check("rst_wea", {28'b0, ram_wea}, 32'h0);
        check("rst_addra", {20'b0, ram_addra}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Starvation: A wins cycles 0-3 and 5-8, B is forced in on 4 and 9.
        for (int c = 0; c < 10; c++) begin
            logic eb;
            eb = (c == 4) || (c == 9);
            step(1'b1, 12'd5, 1'b1, 4'b0000, 12'd8, 32'h0, 1'b0,
                 !eb, eb, eb ? 32'h11223344 : 32'h00B12023, "starve");
        end
        step(1'b0, 12'd0, 1'b0, 4'b0000, 12'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "idle0");

        // A-only reads, back to back.
        step(1'b1, 12'd5, 1'b0, 4'b0000, 12'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h00B12023, "a_rd5");
        step(1'b1, 12'd6, 1'b0, 4'b0000, 12'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, "a_rd6");

        // Byte write to word 8, read by A on the very next cycle.
        step(1'b0, 12'd0, 1'b1, 4'b0011, 12'd8, 32'hAAAA5678, 1'b0, 1'b0, 1'b1, 32'h0, "b_wr8");
        step(1'b1, 12'd8, 1'b0, 4'b0000, 12'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h11225678, "a_rd8");

        // Alternating owners every cycle.
        step(1'b0, 12'd0, 1'b1, 4'b0000, 12'd5, 32'h0, 1'b0, 1'b0, 1'b1, 32'h00B12023, "b_rd5");
        step(1'b1, 12'd6, 1'b0, 4'b0000, 12'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, "alt_a6");
        step(1'b0, 12'd0, 1'b1, 4'b0000, 12'd8, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11225678, "b_rd8");

        // Lock burst: B first waits out A, then owns four cycles.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 12'd5, 1'b1, 4'b1111, 12'd0, 32'h10000000, 1'b1,
                 1'b1, 1'b0, 32'h00B12023, "lock_pre");
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 12'd5, 1'b1, 4'b1111, 12'(i), 32'h10000000 + 32'(i), (i < 3),
                 1'b0, 1'b1, 32'h0, "lock_wr");
        end
        step(1'b1, 12'd2, 1'b0, 4'b0000, 12'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h10000002, "lock_after");

        // Lock released by B dropping its request: A still blocked that cycle.
        step(1'b0, 12'd0, 1'b1, 4'b0000, 12'd6, 32'h0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, "lock_rd6");
        step(1'b1, 12'd5, 1'b0, 4'b0000, 12'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "lock_drop");
        step(1'b1, 12'd5, 1'b0, 4'b0000, 12'd0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h00B12023, "after_drop");
        step(1'b0, 12'd0, 1'b0, 4'b0000, 12'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, "idle1");

        // Reset mid-read: the granted read must never return.
        a_req  = 1'b1;
        a_addr = 12'd5;
        b_req  = 1'b0;
        @(negedge clk);
        check("midrst_a_gnt", {31'b0, a_gnt}, 32'h1);
        rst   = 1'b0;
        a_req = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_a_rvalid_in_rst", {31'b0, a_rvalid}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_a_rvalid", {31'b0, a_rvalid}, 32'h0);
            check("midrst_b_rvalid", {31'b0, b_rvalid}, 32'h0);
        end

        @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
